regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry integer register file. Two write-back sources, EXU (ALU/CSR results) and LSU (load data), share the register file's single write port. A round-robin valid/ready handshake grants the port, and the winner is registered into a one-deep output stage that drives the register file write port. A busy scoreboard tracks destinations issued but not yet written, giving decode a per-operand hazard flag.

## Interface
Parameters:
- XLEN, 32, data width
- AW, 5, register address width (2^AW entries; entry 0 hardwired zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- exu_valid  in  1  EXU write-back request
- exu_ready  out  1  EXU request accepted this cycle
- exu_waddr  in  AW  EXU destination
- exu_wdata  in  XLEN  EXU result
- lsu_valid  in  1  LSU write-back request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_waddr  in  AW  LSU destination
- lsu_wdata  in  XLEN  LSU load data
- rf_wen  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  XLEN  register file write data
- issue_set  in  1  decode issued an instruction with a destination
- issue_addr  in  AW  destination of the issued instruction
- rs1_addr, rs2_addr  in  AW  decode source operands
- rs1_busy, rs2_busy  out  1  operand has a pending write
- wb_cnt  out  32  count of committed register writes

## Operation
- Handshake: a transfer occurs when valid && ready at a rising edge. Ready is combinational from both valids and the priority pointer. At most one ready is high per cycle. Ready never goes high without its own valid.
- Arbitration:
  - Only one valid: that source is granted.
  - Both valid: the source selected by prio is granted (prio=0 selects EXU, prio=1 selects LSU).
  - After any grant, prio points to the non-granted source.
  - With no grant, prio holds.
- Output stage:
  - On a grant, {rf_waddr, rf_wdata} latch the winner's address and data.
  - rf_wen is set to 1 unless the winner's waddr is 0.
  - With no grant, rf_wen is 0 next cycle, and rf_waddr/rf_wdata hold their values.
- x0 handling: writes to address 0 complete the handshake but are dropped. They produce no rf_wen, no wb_cnt increment and no scoreboard change.
- Scoreboard: busy[2^AW] vector.
  - issue_set with issue_addr≠0 sets busy[issue_addr].
  - A cycle with rf_wen=1 clears busy[rf_waddr].
  - Set and clear on the same address in the same edge: set wins, because a newer writer is pending.
  - busy[0] is always 0.
- rsN_busy = busy[rsN_addr]. This is combinational from the registered vector, with no bypass of the clear in the current cycle.
- wb_cnt increments by 1 on each edge where rf_wen=1. It wraps from 0xFFFF_FFFF to 0.
- No ordering is enforced between sources. Two writes to the same register commit in grant order.

## Timing
- Reset (rst=0), asynchronous:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, wb_cnt=0, prio=0.
  - exu_ready=lsu_ready=0 while rst=0.
- Latency: a handshake at edge N gives rf_wen=1 during cycle N..N+1. The register file is written at edge N+1, and busy clears at edge N+1.
- rsN_busy falls in the first cycle in which the register file already holds the new value.
- Throughput: one write per cycle sustained. With both valids held high, grants alternate EXU, LSU, EXU, …
- Reset asserted mid-operation: the pending output-stage write is discarded (rf_wen drops immediately). The scoreboard clears. The first grant after reset release goes to EXU if both are valid.

## Test plan
- Reset check: rst=0 with random inputs → all outputs 0, both readies 0. Release rst, EXU writes x5=0x1234 → rf_wen=1 with waddr=5, wdata=0x1234 one cycle after the handshake; wb_cnt=1.
- Contention: both valid for 4 cycles (EXU x1=0xA, LSU x2=0xB, held) → grants in order EXU, LSU, EXU, LSU. Exactly one ready per cycle. rf writes alternate 1/2.
- x0 drop: LSU writes x0=0xFFFF_FFFF → lsu_ready=1, next cycle rf_wen=0, wb_cnt unchanged, busy unchanged.
- Scoreboard: issue_set x7 → rs1_addr=7 gives rs1_busy=1 next cycle. EXU writes x7 → rs1_busy stays 1 in the rf_wen cycle and is 0 the cycle after.
- Scoreboard collision: x3 busy; in the cycle with rf_wen=1 to x3, also issue_set x3 → busy[3] stays 1.
- Counter wrap and mid-op reset: preload wb_cnt via 2^32−1 writes (or force) then one write → wb_cnt=0. Assert rst during a cycle with rf_wen=1 → rf_wen=0 immediately, busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin EXU/LSU write-back arbiter feeding a one-deep register-file write stage, plus a busy scoreboard.
// Grant at edge N commits at edge N+1; ready is combinational, at most one per cycle, never without its valid.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_waddr,
  input  logic [XLEN-1:0] exu_wdata,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_waddr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            issue_set,
  input  logic [AW-1:0]   issue_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [31:0]     wb_cnt
);

  localparam int NREG = 1 << AW;

  logic            prio;
  logic            grant;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // prio=0 favours EXU, prio=1 favours LSU; both readies are gated off while reset is held
  always_comb begin
    exu_ready = rst & exu_valid & (~lsu_valid | ~prio);
    lsu_ready = rst & lsu_valid & (~exu_valid | prio);
    grant     = exu_ready | lsu_ready;
    win_addr  = exu_ready ? exu_waddr : lsu_waddr;
    win_data  = exu_ready ? exu_wdata : lsu_wdata;
  end

  // A new issue to the register being committed wins: the newer writer is still pending
  always_comb begin
    busy_nxt = busy;
    if (rf_wen)
      busy_nxt[rf_waddr] = 1'b0;
    if (issue_set && (issue_addr != '0))
      busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      prio     <= 1'b0;
      busy     <= '0;
      wb_cnt   <= '0;
    end else begin
      if (grant) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        rf_wen   <= (win_addr != '0);
        prio     <= exu_ready;
      end else begin
        rf_wen   <= 1'b0;
      end
      busy   <= busy_nxt;
      wb_cnt <= wb_cnt + {31'd0, rf_wen};
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention, x0 drop, scoreboard, wrap, mid-op reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, lsu_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_waddr, lsu_waddr;
  logic [31:0] exu_wdata, lsu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_set;
  logic [4:0]  issue_addr, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [31:0] wb_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_set(issue_set), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_cnt(wb_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; lsu_valid = 1'b0; issue_set = 1'b0;
    exu_waddr = '0; lsu_waddr = '0; exu_wdata = '0; lsu_wdata = '0;
    issue_addr = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    exu_valid = 1'b1; lsu_valid = 1'b1; issue_set = 1'b1;
    exu_waddr = 5'($urandom); lsu_waddr = 5'($urandom);
    exu_wdata = $urandom; lsu_wdata = $urandom;
    issue_addr = 5'($urandom); rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({exu_ready, lsu_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {exu_ready, lsu_ready}); end
    n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
    n_tests++; if ({rf_waddr, rf_wdata} !== 37'd0) begin n_fail++; $display("FAIL reset_rf: got %h/%h want 0/0", rf_waddr, rf_wdata); end
    n_tests++; if (wb_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", wb_cnt); end
    n_tests++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", {rs1_busy, rs2_busy}); end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_exu_write();
    exu_valid = 1'b1; exu_waddr = 5'd5; exu_wdata = 32'h1234;
    #1;
    n_tests++; if ({exu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL exu_ready: got %b want 10", {exu_ready, lsu_ready}); end
    step();
    exu_valid = 1'b0;
    n_tests++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++; $display("FAIL exu_commit: got %b/%0d/%h want 1/5/1234", rf_wen, rf_waddr, rf_wdata); end
    step();
    n_tests++; if (wb_cnt !== 32'd1) begin n_fail++; $display("FAIL exu_cnt: got %0d want 1", wb_cnt); end
    n_tests++; if ({rf_wen, rf_waddr} !== {1'b0, 5'd5}) begin n_fail++; $display("FAIL exu_hold: got %b/%0d want 0/5", rf_wen, rf_waddr); end
  endtask

  task automatic test_x0_drop();
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hFFFF_FFFF; rs1_addr = 5'd0;
    #1;
    n_tests++; if ({exu_ready, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL x0_ready: got %b want 01", {exu_ready, lsu_ready}); end
    step();
    lsu_valid = 1'b0;
    n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen: got %b want 0", rf_wen); end
    n_tests++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b want 0", rs1_busy); end
    step();
    n_tests++; if (wb_cnt !== 32'd1) begin n_fail++; $display("FAIL x0_cnt: got %0d want 1", wb_cnt); end
  endtask

  // previous grant went to LSU, so prio favours EXU first
  task automatic test_contention();
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    exu_valid = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'hA;
    lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if ({exu_ready, lsu_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL cont_ready[%0d]: got %b want %b", i, {exu_ready, lsu_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step();
      exp_a = (i % 2 == 0) ? 5'd1 : 5'd2;
      exp_d = (i % 2 == 0) ? 32'hA : 32'hB;
      n_tests++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, exp_a, exp_d}) begin
        n_fail++; $display("FAIL cont_write[%0d]: got %b/%0d/%h want 1/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, exp_a, exp_d);
      end
    end
    exu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    n_tests++; if (wb_cnt !== 32'd5) begin n_fail++; $display("FAIL cont_cnt: got %0d want 5", wb_cnt); end
  endtask

  task automatic test_scoreboard();
    issue_set = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    n_tests++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_pre: got %b want 0", rs1_busy); end
    step();
    issue_set = 1'b0;
    n_tests++; if ({rs1_busy, rs2_busy} !== 2'b11) begin n_fail++; $display("FAIL sb_set: got %b want 11", {rs1_busy, rs2_busy}); end
    exu_valid = 1'b1; exu_waddr = 5'd7; exu_wdata = 32'h77;
    step();
    exu_valid = 1'b0;
    n_tests++; if ({rf_wen, rs1_busy} !== 2'b11) begin n_fail++; $display("FAIL sb_wen_cycle: got wen/busy %b want 11", {rf_wen, rs1_busy}); end
    step();
    n_tests++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL sb_clear: got %b want 00", {rs1_busy, rs2_busy}); end
  endtask

  task automatic test_collision();
    issue_set = 1'b1; issue_addr = 5'd3; rs2_addr = 5'd3;
    step();
    issue_set = 1'b0;
    lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h33;
    step();
    lsu_valid = 1'b0;
    issue_set = 1'b1; issue_addr = 5'd3;
    n_tests++; if ({rf_wen, rf_waddr, rs2_busy} !== {1'b1, 5'd3, 1'b1}) begin n_fail++; $display("FAIL col_wen: got %b/%0d/%b want 1/3/1", rf_wen, rf_waddr, rs2_busy); end
    step();
    issue_set = 1'b0;
    n_tests++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL col_set_wins: got %b want 1", rs2_busy); end
    exu_valid = 1'b1; exu_waddr = 5'd3; exu_wdata = 32'h333;
    step();
    exu_valid = 1'b0;
    step();
    n_tests++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL col_final_clear: got %b want 0", rs2_busy); end
  endtask

  task automatic test_wrap();
    force dut.wb_cnt = 32'hFFFF_FFFF;
    step();
    release dut.wb_cnt;
    n_tests++; if (wb_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", wb_cnt); end
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h99;
    step();
    lsu_valid = 1'b0;
    step();
    n_tests++; if (wb_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt: got %h want 0", wb_cnt); end
  endtask

  task automatic test_midop_reset();
    issue_set = 1'b1; issue_addr = 5'd4; rs1_addr = 5'd4;
    step();
    issue_set = 1'b0;
    exu_valid = 1'b1; exu_waddr = 5'd4; exu_wdata = 32'h44;
    step();
    n_tests++; if ({rf_wen, rs1_busy} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got wen/busy %b want 11", {rf_wen, rs1_busy}); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if ({rf_wen, rs1_busy, exu_ready} !== 3'b000) begin n_fail++; $display("FAIL mid_reset: got wen/busy/rdy %b want 000", {rf_wen, rs1_busy, exu_ready}); end
    n_tests++; if (wb_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", wb_cnt); end
    step();
    exu_waddr = 5'd10; exu_wdata = 32'h10;
    lsu_valid = 1'b1; lsu_waddr = 5'd11; lsu_wdata = 32'h11;
    rst = 1'b1;
    #1;
    n_tests++; if ({exu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_first_grant: got %b want 10", {exu_ready, lsu_ready}); end
    step();
    idle_inputs();
    n_tests++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h10}) begin n_fail++; $display("FAIL mid_commit: got %b/%0d/%h want 1/10/10", rf_wen, rf_waddr, rf_wdata); end
  endtask

  initial begin
    test_reset();
    test_exu_write();
    test_x0_drop();
    test_contention();
    test_scoreboard();
    test_collision();
    test_wrap();
    test_midop_reset();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
